// File: rtl/ballot_pkg.sv
// Shared constants and state encoding for the ballot collector.
package ballot_pkg;

    localparam int unsigned NP_W         = 32;
    localparam int unsigned VIP_W        = 8;
    localparam int unsigned IDX_W        = 5;
    localparam int unsigned CNT_W        = 6;
    localparam int unsigned TOTAL_VOTERS = NP_W + VIP_W + 1;

    localparam logic [1:0] CLS_NP   = 2'd0;
    localparam logic [1:0] CLS_VIP  = 2'd1;
    localparam logic [1:0] CLS_VVIP = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/ballot_decode.sv
// Maps a (class, index) ballot onto a one-hot bit in the concatenated voter
// space {vvip, vip, np} and flags whether the ballot is legal.
//   in_class : ballot class (np / vip / vvip / illegal)
//   in_idx   : voter index within its class
//   sel_c    : one-hot select, all zero when illegal
//   legal_c  : ballot addresses an existing voter
module ballot_decode
    import ballot_pkg::*;
#(
    parameter int unsigned NP_W_P  = NP_W,
    parameter int unsigned VIP_W_P = VIP_W,
    parameter int unsigned IDX_W_P = IDX_W
) (
    input  logic [1:0]                     in_class,
    input  logic [IDX_W_P-1:0]             in_idx,
    output logic [NP_W_P+VIP_W_P:0]        sel_c,
    output logic                           legal_c
);

    localparam int unsigned TOT_W = NP_W_P + VIP_W_P + 1;

    always_comb begin
        sel_c   = '0;
        legal_c = 1'b0;
        case (in_class)
            CLS_NP: begin
                if (32'(in_idx) < NP_W_P) begin
                    legal_c = 1'b1;
                    sel_c   = TOT_W'(1) << in_idx;
                end
            end
            CLS_VIP: begin
                if (32'(in_idx) < VIP_W_P) begin
                    legal_c = 1'b1;
                    sel_c   = TOT_W'(1) << (NP_W_P + 32'(in_idx));
                end
            end
            CLS_VVIP: begin
                if (in_idx == '0) begin
                    legal_c = 1'b1;
                    sel_c   = TOT_W'(1) << (TOT_W - 1);
                end
            end
            default: begin
                sel_c   = '0;
                legal_c = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ballot_collector.sv
// Collects ballots one per cycle during an open round and presents the
// assembled np / vip / vvip yes-vectors on a valid/ack handshake.
//   clk, reset (async, active-low)
//   start / close     : open / end a round (pulses)
//   in_valid/in_ready : ballot handshake; in_class, in_idx, in_yes payload
//   np, vip, vvip     : collected yes-vectors
//   voted_cnt         : distinct voters this round
//   dup_err, bad_err  : sticky repeat / illegal ballot flags
//   out_valid/out_ack : result handshake; busy high in COLLECT and DONE
module ballot_collector
    import ballot_pkg::*;
#(
    parameter int unsigned NP_W_P  = NP_W,
    parameter int unsigned VIP_W_P = VIP_W,
    parameter int unsigned IDX_W_P = IDX_W,
    parameter int unsigned CNT_W_P = CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 close,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_class,
    input  logic [IDX_W_P-1:0]   in_idx,
    input  logic                 in_yes,
    output logic [NP_W_P-1:0]    np,
    output logic [VIP_W_P-1:0]   vip,
    output logic                 vvip,
    output logic [CNT_W_P-1:0]   voted_cnt,
    output logic                 dup_err,
    output logic                 bad_err,
    output logic                 out_valid,
    input  logic                 out_ack,
    output logic                 busy
);

    localparam int unsigned TOT_W = NP_W_P + VIP_W_P + 1;

    state_t               state_q, state_d;
    logic [TOT_W-1:0]     mask_q, vec_q;
    logic [CNT_W_P-1:0]   cnt_q;
    logic                 dup_q, bad_q, out_valid_q, in_ready_q, busy_q;

    logic [TOT_W-1:0]     sel_c;
    logic                 legal_c, accept_c, repeat_c, fresh_c, last_c;

    ballot_decode #(
        .NP_W_P  (NP_W_P),
        .VIP_W_P (VIP_W_P),
        .IDX_W_P (IDX_W_P)
    ) u_decode (
        .in_class (in_class),
        .in_idx   (in_idx),
        .sel_c    (sel_c),
        .legal_c  (legal_c)
    );

    // in_ready_q is only ever high in COLLECT, so it qualifies acceptance.
    assign accept_c = in_valid && in_ready_q;
    assign repeat_c = |(mask_q & sel_c);
    assign fresh_c  = accept_c && legal_c && !repeat_c;
    assign last_c   = fresh_c && (cnt_q == CNT_W_P'(TOT_W - 1));

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start)           state_d = S_COLLECT;
            S_COLLECT: if (close || last_c) state_d = S_DONE;
            S_DONE:    if (out_ack)         state_d = S_IDLE;
            default:                        state_d = S_IDLE;
        endcase
    end

    // State register plus handshake outputs derived from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == S_COLLECT);
            out_valid_q <= (state_d == S_DONE);
            busy_q      <= (state_d != S_IDLE);
        end
    end

    // Round data: cleared on start, updated per accepted ballot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q <= '0;
            vec_q  <= '0;
            cnt_q  <= '0;
            dup_q  <= 1'b0;
            bad_q  <= 1'b0;
        end else if (state_q == S_IDLE && start) begin
            mask_q <= '0;
            vec_q  <= '0;
            cnt_q  <= '0;
            dup_q  <= 1'b0;
            bad_q  <= 1'b0;
        end else if (accept_c) begin
            if (!legal_c) begin
                bad_q <= 1'b1;
            end else if (repeat_c) begin
                dup_q <= 1'b1;
            end else begin
                mask_q <= mask_q | sel_c;
                vec_q  <= (vec_q & ~sel_c) | (in_yes ? sel_c : '0);
                cnt_q  <= cnt_q + CNT_W_P'(1);
            end
        end
    end

    assign np        = vec_q[NP_W_P-1:0];
    assign vip       = vec_q[NP_W_P+VIP_W_P-1:NP_W_P];
    assign vvip      = vec_q[TOT_W-1];
    assign voted_cnt = cnt_q;
    assign dup_err   = dup_q;
    assign bad_err   = bad_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ballot_collector.sv
// Scoreboard bench for ballot_collector: stimulus pushes the expected round
// result, a monitor pops and compares when out_valid rises.
module tb_ballot_collector;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, close, in_valid, in_yes, out_ack;
    logic [1:0]  in_class;
    logic [4:0]  in_idx;
    logic        in_ready, vvip, dup_err, bad_err, out_valid, busy;
    logic [31:0] np;
    logic [7:0]  vip;
    logic [5:0]  voted_cnt;

    typedef struct {
        logic [31:0] np;
        logic [7:0]  vip;
        logic        vvip;
        logic [5:0]  cnt;
        logic        dup;
        logic        bad;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    logic seen  = 1'b0;

    always #5 clk = ~clk;

    ballot_collector dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .close     (close),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_class  (in_class),
        .in_idx    (in_idx),
        .in_yes    (in_yes),
        .np        (np),
        .vip       (vip),
        .vvip      (vvip),
        .voted_cnt (voted_cnt),
        .dup_err   (dup_err),
        .bad_err   (bad_err),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] e_np, input logic [7:0] e_vip, input logic e_vvip,
                        input logic [5:0] e_cnt, input logic e_dup, input logic e_bad);
        exp_t e;
        e.np = e_np; e.vip = e_vip; e.vvip = e_vvip;
        e.cnt = e_cnt; e.dup = e_dup; e.bad = e_bad;
        exp_q.push_back(e);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic ballot(input logic [1:0] cls, input logic [4:0] idx, input logic yes);
        in_valid = 1'b1; in_class = cls; in_idx = idx; in_yes = yes;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_close();
        close = 1'b1;
        tick();
        close = 1'b0;
    endtask

    task automatic do_ack();
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
    endtask

    // Monitor: one comparison set per out_valid assertion.
    always @(negedge clk) begin
        if (out_valid && !seen) begin
            seen <= 1'b1;
            if (exp_q.size() == 0) begin
                check("unexpected_result", 64'(1), 64'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("np",        64'(np),        64'(e.np));
                check("vip",       64'(vip),       64'(e.vip));
                check("vvip",      64'(vvip),      64'(e.vvip));
                check("voted_cnt", 64'(voted_cnt), 64'(e.cnt));
                check("dup_err",   64'(dup_err),   64'(e.dup));
                check("bad_err",   64'(bad_err),   64'(e.bad));
            end
        end else if (!out_valid) begin
            seen <= 1'b0;
        end
    end

    initial begin
        reset = 1'b0; start = 1'b0; close = 1'b0; in_valid = 1'b0;
        in_class = 2'd0; in_idx = 5'd0; in_yes = 1'b0; out_ack = 1'b0;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready",  64'(in_ready),  64'(0));
        check("rst_busy",      64'(busy),      64'(0));
        check("rst_cnt",       64'(voted_cnt), 64'(0));
        reset = 1'b1;
        tick();

        // Basic round closed early.
        do_start();
        check("t1_in_ready", 64'(in_ready), 64'(1));
        check("t1_busy",     64'(busy),     64'(1));
        ballot(2'd0, 5'd3, 1'b1);
        check("t1_np_lat1",  64'(np), 64'h8);
        ballot(2'd1, 5'd7, 1'b1);
        ballot(2'd2, 5'd0, 1'b0);
        check("t1_pre_close_valid", 64'(out_valid), 64'(0));
        push(32'h0000_0008, 8'h80, 1'b0, 6'd3, 1'b0, 1'b0);
        do_close();
        check("t1_out_valid", 64'(out_valid), 64'(1));
        check("t1_in_ready_done", 64'(in_ready), 64'(0));
        do_ack();

        // Full round, in_valid held continuously, auto DONE on 41st.
        do_start();
        in_valid = 1'b1; in_yes = 1'b1;
        for (int i = 0; i < 41; i++) begin
            if (i < 32)      begin in_class = 2'd0; in_idx = 5'(i);      end
            else if (i < 40) begin in_class = 2'd1; in_idx = 5'(i - 32); end
            else             begin in_class = 2'd2; in_idx = 5'd0;       end
            if (i == 40) begin
                check("t2_ready_last", 64'(in_ready),  64'(1));
                check("t2_valid_last", 64'(out_valid), 64'(0));
                push(32'hFFFF_FFFF, 8'hFF, 1'b1, 6'd41, 1'b0, 1'b0);
            end
            tick();
        end
        in_valid = 1'b0;
        check("t2_auto_done", 64'(out_valid), 64'(1));
        check("t2_in_ready",  64'(in_ready),  64'(0));
        do_ack();

        // Duplicate ballot: first vote stands.
        do_start();
        ballot(2'd0, 5'd5, 1'b1);
        ballot(2'd0, 5'd5, 1'b0);
        check("t3_dup_live", 64'(dup_err), 64'(1));
        // out_ack outside DONE must have no effect.
        do_ack();
        check("t3_ack_ignored", 64'(busy), 64'(1));
        push(32'h0000_0020, 8'h00, 1'b0, 6'd1, 1'b1, 1'b0);
        do_close();
        do_ack();

        // Illegal ballots.
        do_start();
        ballot(2'd3, 5'd0, 1'b1);
        check("t4_ready_a", 64'(in_ready), 64'(1));
        ballot(2'd1, 5'd9, 1'b1);
        check("t4_ready_b", 64'(in_ready), 64'(1));
        ballot(2'd2, 5'd1, 1'b1);
        check("t4_ready_c", 64'(in_ready), 64'(1));
        push(32'h0, 8'h00, 1'b0, 6'd0, 1'b0, 1'b1);
        do_close();
        check("t4_done", 64'(out_valid), 64'(1));
        do_ack();

        // Ballot accepted together with close; start/in_valid ignored in DONE.
        do_start();
        in_valid = 1'b1; in_class = 2'd1; in_idx = 5'd2; in_yes = 1'b1; close = 1'b1;
        push(32'h0, 8'h04, 1'b0, 6'd1, 1'b0, 1'b0);
        tick();
        close = 1'b0;
        check("t5_done_next", 64'(out_valid), 64'(1));
        start = 1'b1; in_idx = 5'd3;
        tick(); tick();
        start = 1'b0; in_valid = 1'b0;
        check("t5_hold_valid", 64'(out_valid), 64'(1));
        check("t5_hold_vip",   64'(vip),       64'h04);
        check("t5_hold_cnt",   64'(voted_cnt), 64'(1));
        do_ack();
        check("t5_ack_valid", 64'(out_valid), 64'(0));
        check("t5_idle_busy", 64'(busy),      64'(0));
        check("t5_idle_vip",  64'(vip),       64'h04);

        // Asynchronous reset mid-round.
        do_start();
        for (int i = 0; i < 10; i++) ballot(2'd0, 5'(i), 1'b1);
        check("t6_cnt10", 64'(voted_cnt), 64'(10));
        #2 reset = 1'b0;
        #1;
        check("t6_rst_np",    64'(np),        64'(0));
        check("t6_rst_cnt",   64'(voted_cnt), 64'(0));
        check("t6_rst_ready", 64'(in_ready),  64'(0));
        check("t6_rst_busy",  64'(busy),      64'(0));
        tick();
        reset = 1'b1;
        tick();
        do_start();
        push(32'h0, 8'h00, 1'b0, 6'd0, 1'b0, 1'b0);
        do_close();
        do_ack();
        tick();

        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ballot_collector.md
Name: ballot_collector

Overview:
- Sequential front end for the vote block: collects individual ballots one at a time over a valid/ready handshake during an open round.
- Assembles the np (32 ordinary), vip (8 VIP) and vvip (1) yes-vectors that the vote block consumes.
- Presents the vectors on a valid/ack output handshake once the round closes.
- Sits between the voter-side bus and the combinational vote decision logic.

Parameters:
- NP_W, 32, number of ordinary voters; width of np.
- VIP_W, 8, number of VIP voters; width of vip.
- IDX_W, 5, ballot index width; must satisfy 2**IDX_W >= NP_W.
- CNT_W, 6, width of voted_cnt; must hold NP_W+VIP_W+1 = 41.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; opens a round.
- close  in  1  single-cycle pulse; ends the round early.
- in_valid  in  1  ballot present.
- in_ready  out  1  ballot accepted when in_valid && in_ready.
- in_class  in  2  0 = np, 1 = vip, 2 = vvip, 3 = illegal.
- in_idx  in  IDX_W  voter index within its class.
- in_yes  in  1  1 = yes vote.
- np  out  NP_W  collected ordinary yes-vector.
- vip  out  VIP_W  collected VIP yes-vector.
- vvip  out  1  collected VVIP vote.
- voted_cnt  out  CNT_W  number of distinct voters who have voted this round.
- dup_err  out  1  sticky: a repeat ballot was seen this round.
- bad_err  out  1  sticky: an illegal ballot was seen this round.
- out_valid  out  1  vectors final; held high until out_ack.
- out_ack  in  1  consumer has taken the result.
- busy  out  1  high in COLLECT and DONE.

Behaviour:
- Reset (asynchronous, reset=0): state IDLE; np, vip, vvip, voted_cnt, all internal voted-masks, dup_err, bad_err, out_valid, in_ready, busy all 0.
- States and transitions:
  - IDLE: start -> COLLECT. The same edge clears np, vip, vvip, masks, voted_cnt, dup_err and bad_err. All other inputs ignored.
  - COLLECT: in_ready = 1 (registered; high the cycle after start). Accept a ballot on each in_valid && in_ready edge, one per cycle, zero-bubble. Leave for DONE on close, or automatically on the edge that accepts the 41st distinct voter.
  - DONE: in_ready = 0, out_valid = 1. out_ack -> IDLE with out_valid = 0. np, vip and vvip hold their values until the next start.
- Ballot legality:
  - Legal: class 0 with idx < NP_W; class 1 with idx < VIP_W; class 2 with idx == 0.
  - Anything else sets bad_err. The ballot is consumed and has no other effect.
- Duplicates: a legal ballot for a voter already marked in the voted-mask sets dup_err. The first vote stands; voted_cnt is unchanged.
- Legal first ballot: sets that voter's mask bit, writes in_yes into the matching output bit, increments voted_cnt. The output is visible the cycle after acceptance.
- Voters who never vote read as 0 (no).
- Simultaneous events:
  - close together with an accepted ballot: the ballot is recorded, then DONE.
  - start while in COLLECT or DONE: ignored.
  - out_ack while not in DONE: ignored.
  - close outside COLLECT: ignored.
- voted_cnt saturates at 41 by construction (duplicates are not counted) and never wraps.
- Latency: ballot to output bit, 1 cycle; last ballot or close to out_valid, 1 cycle.
- Reset asserted mid-round: immediate return to IDLE with all outputs cleared; any partial round is discarded.

Decomposition:
- Package ballot_pkg:
  - class constants CLS_NP = 2'd0, CLS_VIP = 2'd1, CLS_VVIP = 2'd2;
  - state encoding S_IDLE, S_COLLECT, S_DONE;
  - TOTAL_VOTERS = 41.
- One combinational sub-module, ballot_decode: inputs in_class and in_idx; outputs a one-hot select into the concatenated 41-bit voter space plus a legal flag.
- The top module holds the FSM, masks, counter and output registers.

Test Plan:
- Reset, start, then np idx 3 yes, vip idx 7 yes, vvip idx 0 no, then close -> np=32'h0000_0008, vip=8'h80, vvip=0, voted_cnt=3, out_valid=1 one cycle after close, errors 0.
- Full round of 41 ballots, all yes, in_valid held continuously -> auto DONE on the 41st acceptance; np=32'hFFFF_FFFF, vip=8'hFF, vvip=1, voted_cnt=41, no close needed.
- np idx 5 yes, then np idx 5 no -> np bit5 stays 1, dup_err=1, voted_cnt=1.
- Ballots with class 3, vip idx 9, and vvip idx 1 -> bad_err=1; all vectors 0, voted_cnt=0; in_ready stays 1 throughout.
- Accept vip idx 2 yes in the same cycle as close -> vip=8'h04, DONE next cycle; later start and in_valid are ignored until out_ack; after out_ack, out_valid=0 and the state is IDLE.
- Reset pulsed low mid-COLLECT with voted_cnt=10 -> all outputs 0 immediately (asynchronously); the next start opens a clean round.
